// File: rtl/csr_pkg.sv
// Shared CSR definitions: address map, trap-vector mode encoding and vector stride.
package csr_pkg;

   localparam logic [11:0] CSR_MTVEC = 12'h305;
   localparam logic [11:0] CSR_STVEC = 12'h105;

   typedef enum logic [1:0] {
      TVEC_DIRECT   = 2'd0,
      TVEC_VECTORED = 2'd1
   } tvec_mode_t;

   // Vectored interrupts land at BASE + cause * 4.
   localparam int TVEC_VEC_SHIFT = 2;

endpackage : csr_pkg

// File: rtl/csr_tvec_if.sv
// CSR access and trap-target bundle between the core (master) and the tvec CSR (slave).
interface csr_tvec_if #(
   parameter int XLEN    = 32,
   parameter int CAUSE_W = 5
);
   logic               en_i;
   logic [11:0]        addr_i;
   logic [XLEN-1:0]    set_i;
   logic [XLEN-1:0]    clear_i;
   logic               ack_o;
   logic [XLEN-1:0]    rdata_o;
   logic               trap_i;
   logic               trap_irq_i;
   logic [CAUSE_W-1:0] trap_cause_i;
   logic               target_valid_o;
   logic [XLEN-1:0]    target_pc_o;
   logic [XLEN-1:0]    value_o;

   modport master (
      output en_i, addr_i, set_i, clear_i, trap_i, trap_irq_i, trap_cause_i,
      input  ack_o, rdata_o, target_valid_o, target_pc_o, value_o
   );

   modport slave (
      input  en_i, addr_i, set_i, clear_i, trap_i, trap_irq_i, trap_cause_i,
      output ack_o, rdata_o, target_valid_o, target_pc_o, value_o
   );
endinterface : csr_tvec_if

// File: rtl/csrfield.sv
// Generic writable CSR field: a reset-initialised register with a write enable.
module csrfield #(
   parameter int           W     = 1,
   parameter logic [W-1:0] RESET = '0
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         we_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] q_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         q_q <= RESET;
      end else if (we_i) begin
         q_q <= d_i;
      end else begin
         q_q <= q_q;
      end
   end

   assign q_o = q_q;
endmodule : csrfield

// File: rtl/tvec_target.sv
// Trap-target computation (direct or vectored) with registered valid pulse and PC.
module tvec_target
   import csr_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int CAUSE_W = 5
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               trap_i,
   input  logic               irq_i,
   input  logic [CAUSE_W-1:0] cause_i,
   input  logic [XLEN-1:0]    base_i,
   input  tvec_mode_t         mode_i,
   output logic               valid_o,
   output logic [XLEN-1:0]    pc_o
);
   logic [XLEN-1:0] offset_s;
   logic [XLEN-1:0] pc_d;
   logic            valid_q;
   logic [XLEN-1:0] pc_q;

   assign offset_s = XLEN'(cause_i) << TVEC_VEC_SHIFT;

   // Exceptions always go to BASE; only interrupts in vectored mode are offset (wrap is allowed).
   always_comb begin
      pc_d = pc_q;
      if (trap_i) begin
         if ((mode_i == TVEC_VECTORED) && irq_i) begin
            pc_d = base_i + offset_s;
         end else begin
            pc_d = base_i;
         end
      end else begin
         pc_d = pc_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
      end else begin
         valid_q <= trap_i;
         pc_q    <= pc_d;
      end
   end

   assign valid_o = valid_q;
   assign pc_o    = pc_q;
endmodule : tvec_target

// File: rtl/csr_tvec.sv
// Trap-vector CSR (mtvec/stvec): BASE + WARL MODE, registered read-back and trap target.
// Optional write lock enabled by defining CSR_TVEC_LOCK_EN (adds lock_i).
module csr_tvec
   import csr_pkg::*;
#(
   parameter int              XLEN             = 32,
   parameter logic [11:0]     ADDRESS          = CSR_MTVEC,
   parameter int              BASE_ALIGN       = 2,
   parameter logic [XLEN-1:0] RESET_BASE       = '0,
   parameter int              VECTORED_SUPPORT = 1,
   parameter int              CAUSE_W          = 5
) (
   input  logic          clk_i,
   input  logic          rst_i,
`ifdef CSR_TVEC_LOCK_EN
   input  logic          lock_i,
`endif
   csr_tvec_if.slave     bus
);
   localparam int BW = XLEN - BASE_ALIGN;

   logic [BW-1:0]   base_s;
   logic [XLEN-1:0] base_full_s;
   logic [XLEN-1:0] value_s;
   logic [XLEN-1:0] next_s;
   logic            hit_s;
   logic            write_s;
   tvec_mode_t      mode_q;
   tvec_mode_t      mode_d;
   logic            ack_q;
   logic [XLEN-1:0] rdata_q;

   assign hit_s       = bus.en_i && (bus.addr_i == ADDRESS);
   assign base_full_s = {base_s, {BASE_ALIGN{1'b0}}};
   assign value_s     = base_full_s | {{(XLEN-2){1'b0}}, mode_q};
   assign next_s      = (value_s & ~bus.clear_i) | bus.set_i;

`ifdef CSR_TVEC_LOCK_EN
   logic lock_q;

   // Sticky lock; a write in the same cycle as lock_i still commits.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lock_q <= 1'b0;
      end else begin
         lock_q <= lock_q | lock_i;
      end
   end

   assign write_s = hit_s && !lock_q;
`else
   assign write_s = hit_s;
`endif

   csrfield #(
      .W     (BW),
      .RESET (RESET_BASE[XLEN-1:BASE_ALIGN])
   ) u_base (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .we_i  (write_s),
      .d_i   (next_s[XLEN-1:BASE_ALIGN]),
      .q_o   (base_s)
   );

   // MODE is WARL: illegal encodings leave it unchanged while BASE still updates.
   always_comb begin
      mode_d = mode_q;
      if (write_s) begin
         case (next_s[1:0])
            2'd0: mode_d = TVEC_DIRECT;
            2'd1: begin
               if (VECTORED_SUPPORT != 0) begin
                  mode_d = TVEC_VECTORED;
               end else begin
                  mode_d = mode_q;
               end
            end
            default: mode_d = mode_q;
         endcase
      end else begin
         mode_d = mode_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mode_q <= TVEC_DIRECT;
      end else begin
         mode_q <= mode_d;
      end
   end

   // Read-old semantics: rdata captures the value before this cycle's write.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ack_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         ack_q   <= hit_s;
         rdata_q <= hit_s ? value_s : rdata_q;
      end
   end

   tvec_target #(
      .XLEN    (XLEN),
      .CAUSE_W (CAUSE_W)
   ) u_target (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .trap_i  (bus.trap_i),
      .irq_i   (bus.trap_irq_i),
      .cause_i (bus.trap_cause_i),
      .base_i  (base_full_s),
      .mode_i  (mode_q),
      .valid_o (bus.target_valid_o),
      .pc_o    (bus.target_pc_o)
   );

   assign bus.ack_o   = ack_q;
   assign bus.rdata_o = rdata_q;
   assign bus.value_o = value_s;
endmodule : csr_tvec

// File: tb/tb_csr_tvec.sv
// Self-checking bench for csr_tvec: two instances (vectored supported / not) against a reference model.
module tb_csr_tvec;
   localparam logic [31:0] RB = 32'h8000_0100;

`ifdef CSR_TVEC_LOCK_EN
   localparam bit LOCK_BUILD = 1'b1;
`else
   localparam bit LOCK_BUILD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic lock = 1'b0;

   always #5 clk = ~clk;

   csr_tvec_if #(.XLEN(32), .CAUSE_W(5)) if0 ();
   csr_tvec_if #(.XLEN(32), .CAUSE_W(5)) if1 ();

   csr_tvec #(.XLEN(32), .ADDRESS(12'h305), .BASE_ALIGN(2), .RESET_BASE(RB),
              .VECTORED_SUPPORT(1), .CAUSE_W(5)) dut0 (
      .clk_i (clk),
      .rst_i (rst),
`ifdef CSR_TVEC_LOCK_EN
      .lock_i(lock),
`endif
      .bus   (if0)
   );

   csr_tvec #(.XLEN(32), .ADDRESS(12'h305), .BASE_ALIGN(2), .RESET_BASE(RB),
              .VECTORED_SUPPORT(0), .CAUSE_W(5)) dut1 (
      .clk_i (clk),
      .rst_i (rst),
`ifdef CSR_TVEC_LOCK_EN
      .lock_i(lock),
`endif
      .bus   (if1)
   );

   // Reference model state, index 0 = vectored supported, 1 = not supported.
   logic [31:0] m_val [2];
   logic [31:0] m_rd  [2];
   logic [31:0] m_pc  [2];
   logic        m_ack [2];
   logic        m_tv  [2];
   logic        m_lock[2];
   bit          m_vec [2];

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("d0_ack",   {31'd0, if0.ack_o},          {31'd0, m_ack[0]});
      chk("d0_rdata", if0.rdata_o,                 m_rd[0]);
      chk("d0_value", if0.value_o,                 m_val[0]);
      chk("d0_tv",    {31'd0, if0.target_valid_o}, {31'd0, m_tv[0]});
      chk("d0_pc",    if0.target_pc_o,             m_pc[0]);
      chk("d1_ack",   {31'd0, if1.ack_o},          {31'd0, m_ack[1]});
      chk("d1_rdata", if1.rdata_o,                 m_rd[1]);
      chk("d1_value", if1.value_o,                 m_val[1]);
      chk("d1_tv",    {31'd0, if1.target_valid_o}, {31'd0, m_tv[1]});
      chk("d1_pc",    if1.target_pc_o,             m_pc[1]);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_val[k]  = RB & 32'hFFFF_FFFC;
         m_rd[k]   = 32'd0;
         m_pc[k]   = 32'd0;
         m_ack[k]  = 1'b0;
         m_tv[k]   = 1'b0;
         m_lock[k] = 1'b0;
      end
   endtask

   // New CSR value from the architectural rules: set/clear, 4-byte BASE, WARL MODE.
   function automatic logic [31:0] apply_write(input logic [31:0] cur, input logic [31:0] set,
                                               input logic [31:0] clr, input bit vec);
      logic [31:0] nx;
      logic [1:0]  md;
      nx = (cur & ~clr) | set;
      md = cur[1:0];
      if (nx[1:0] == 2'd0) md = 2'd0;
      else if (nx[1:0] == 2'd1 && vec) md = 2'd1;
      return {nx[31:2], md};
   endfunction

   task automatic step(input logic en, input logic [11:0] addr, input logic [31:0] set,
                       input logic [31:0] clr, input logic trap, input logic irq,
                       input logic [4:0] cause, input logic lk);
      logic [31:0] base;
      if0.en_i = en;  if0.addr_i = addr;  if0.set_i = set;  if0.clear_i = clr;
      if0.trap_i = trap;  if0.trap_irq_i = irq;  if0.trap_cause_i = cause;
      if1.en_i = en;  if1.addr_i = addr;  if1.set_i = set;  if1.clear_i = clr;
      if1.trap_i = trap;  if1.trap_irq_i = irq;  if1.trap_cause_i = cause;
      lock = lk;
      for (int k = 0; k < 2; k++) begin
         base = m_val[k] & 32'hFFFF_FFFC;
         m_tv[k] = trap;
         if (trap) begin
            if (m_val[k][1:0] == 2'd1 && irq) m_pc[k] = base + {27'd0, cause} * 32'd4;
            else m_pc[k] = base;
         end
         m_ack[k] = en && (addr == 12'h305);
         if (m_ack[k]) begin
            m_rd[k] = m_val[k];
            if (!m_lock[k]) m_val[k] = apply_write(m_val[k], set, clr, m_vec[k]);
         end
         if (lk && LOCK_BUILD) m_lock[k] = 1'b1;
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle();
      step(1'b0, 12'h000, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
   endtask

   initial begin
      m_vec[0] = 1'b1;
      m_vec[1] = 1'b0;
      model_reset();
      if0.en_i = 1'b0; if0.addr_i = 12'h000; if0.set_i = 32'd0; if0.clear_i = 32'd0;
      if0.trap_i = 1'b0; if0.trap_irq_i = 1'b0; if0.trap_cause_i = 5'd0;
      if1.en_i = 1'b0; if1.addr_i = 12'h000; if1.set_i = 32'd0; if1.clear_i = 32'd0;
      if1.trap_i = 1'b0; if1.trap_irq_i = 1'b0; if1.trap_cause_i = 5'd0;

      // Reset state
      repeat (2) @(negedge clk);
      check_all();
      chk("reset_value", if0.value_o, 32'h8000_0100);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Read-back of reset value
      step(1'b1, 12'h305, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      chk("tp1_rdata", if0.rdata_o, 32'h8000_0100);

      // WARL MODE
      step(1'b1, 12'h305, 32'h0000_2001, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0, 1'b0);
      chk("tp2_vec", if0.value_o, 32'h0000_2001);
      chk("tp2_novec", if1.value_o, 32'h0000_2000);
      step(1'b1, 12'h305, 32'h0000_0003, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      chk("tp2_mode3", if0.value_o, 32'h0000_2001);

      // Vectored interrupt and exception targets
      step(1'b0, 12'h000, 32'd0, 32'd0, 1'b1, 1'b1, 5'd7, 1'b0);
      chk("tp3_irq", if0.target_pc_o, 32'h0000_201C);
      step(1'b0, 12'h000, 32'd0, 32'd0, 1'b1, 1'b0, 5'd7, 1'b0);
      chk("tp3_exc", if0.target_pc_o, 32'h0000_2000);
      idle();

      // Trap and write in the same cycle
      step(1'b1, 12'h305, 32'h0000_4000, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd3, 1'b0);
      chk("tp4_pc", if0.target_pc_o, 32'h0000_200C);
      chk("tp4_value", if0.value_o, 32'h0000_4000);

      // Other CSR address ignored
      step(1'b1, 12'h105, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);

      // Target wrap-around
      step(1'b1, 12'h305, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0, 1'b0);
      step(1'b0, 12'h000, 32'd0, 32'd0, 1'b1, 1'b1, 5'd31, 1'b0);
      chk("wrap_pc", if0.target_pc_o, 32'h0000_006C);

      // Asynchronous reset drops a pending ack and target pulse
      step(1'b1, 12'h305, 32'h0000_0040, 32'd0, 1'b1, 1'b1, 5'd1, 1'b0);
      #1;
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      if0.en_i = 1'b0; if0.trap_i = 1'b0;
      if1.en_i = 1'b0; if1.trap_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      idle();

      // Randomised traffic
      for (int i = 0; i < 300; i++) begin
         logic [11:0] a;
         logic [31:0] s;
         logic [31:0] c;
         case ($urandom_range(0, 3))
            0, 1:    a = 12'h305;
            2:       a = 12'h105;
            default: a = 12'($urandom_range(0, 4095));
         endcase
         s = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         c = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : $urandom;
         step(1'($urandom_range(0, 1)), a, s, c, ($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'b0);
      end

`ifdef CSR_TVEC_LOCK_EN
      // Lock: subsequent writes are acknowledged but ignored
      step(1'b1, 12'h305, 32'h0000_0800, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0, 1'b1);
      chk("lock_commit", if0.value_o, 32'h0000_0800);
      step(1'b1, 12'h305, 32'h0000_1000, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      chk("lock_ack", {31'd0, if0.ack_o}, 32'd1);
      chk("lock_value", if0.value_o, 32'h0000_0800);
      idle();
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule : tb_csr_tvec
